dma_axi_w_burst: RTL
====================

// Module: dma_axi_w_burst
// PURPOSE
//  AXI4 write master for the DMA engine. Accepts one transfer command (start address + beat count) and a
//  valid/ready data stream. Splits the transfer into INCR bursts of at most MAX_BURST beats that never
//  cross a 4KB boundary. Buffers stream data in a FIFO so W beats are issued independently of stream gaps.
//  Replaces the single-burst, fixed-length write channel of the DMA.
// PARAMETERS
//  ADDR_W       `AXI_ADDR_W  AXI/byte address width
//  DMA_DATA_W   32           data width (8..1024, power of 2); awsize = clog2(DMA_DATA_W/8)
//  LEN_W        16           width of transfer length in beats
//  MAX_BURST    256          max beats per burst (1..256, power of 2)
//  FIFO_ADDR_W  4            write-data FIFO depth = 2**FIFO_ADDR_W entries
// PORTS
//  clk            in   1             clock
//  rst            in   1             asynchronous active-high reset
//  start          in   1             command strobe; accepted only when busy=0
//  start_addr     in   ADDR_W        byte address; low clog2(DMA_DATA_W/8) bits forced to 0
//  xfer_len       in   LEN_W         transfer length in beats (0 = empty transfer)
//  busy           out  1             command in progress
//  done           out  1             1-cycle pulse when the transfer completes
//  error          out  1             sticky: some bresp != OKAY; cleared on accepted start
//  valid/ready    in/out 1           stream handshake; ready = busy & !fifo_full & beats_in < xfer_len
//  wdata          in   DMA_DATA_W    stream data
//  wstrb          in   DMA_DATA_W/8  stream byte strobes
//  m_axi_aw*      out  `AXI_*_W      awid=0, awburst=INCR, awlock=0, awcache=2, awprot=3'b010, awqos=0
//  m_axi_awvalid/awready out/in 1    address handshake
//  m_axi_wdata/wstrb/wlast/wvalid out, m_axi_wready in   write-data channel
//  m_axi_bresp in `AXI_RESP_W, m_axi_bvalid in 1, m_axi_bready out 1   response channel
// BEHAVIOUR
//  Reset: busy=0, done=0, error=0, ready=0, awvalid=0, wvalid=0, wlast=0, bready=0; FIFO empty; FSM IDLE.
//  FSM states: IDLE, ADDR, DATA, RESP.
//  IDLE: on start, latch addr and rem=xfer_len, clear error, busy=1. If xfer_len=0, done pulses the next
//   cycle, busy returns to 0, and no AXI activity occurs. Otherwise -> ADDR.
//   A start while busy=1 is ignored.
//  ADDR: blen = min(rem, MAX_BURST, (4096 - addr[11:0]) >> awsize).
//   Registered awvalid is asserted the cycle after entry (start->awvalid latency 1 cycle).
//   awaddr=addr and awlen=blen-1 are held stable until awready. On the handshake -> DATA.
//  DATA: wvalid = !fifo_empty. A FIFO pop happens only on wvalid&wready, so wvalid never drops without a
//   handshake. wdata/wstrb come from the FIFO head. A beat counter is cleared on entry.
//   wlast=1 exactly when beat==blen-1. On the last-beat handshake -> RESP.
//  RESP: bready=1 only in this state. On bvalid: error |= (bresp != 2'b00); rem -= blen;
//   addr += blen << awsize (wraps mod 2**ADDR_W). Then -> ADDR if rem != 0, else IDLE with a done pulse
//   and busy=0 in the same cycle.
//  Errors do not abort; all remaining bursts are still issued.
//  The stream side fills the FIFO in any state while busy. The total stream beats accepted equals xfer_len;
//   ready=0 after the last beat. A simultaneous FIFO push and pop on a full FIFO is allowed.
//  Widths: rem and the stream beat count are LEN_W; blen and the beat counter are clog2(MAX_BURST)+1 bits;
//   the 4KB computation uses 13 bits.
//  Reset mid-operation: all state is discarded and outputs return to reset values. No AXI completion is
//   awaited; the system must reset the slave too.
// STRUCTURE
//  Shared package (axi.vh): existing `AXI_* width macros, plus `AXI_4K_W=12 and `AXI_RESP_OKAY=2'b00.
//  Local defines: state encodings W_IDLE/W_ADDR/W_DATA/W_RESP, 2-bit.
//  One sub-module: dma_w_fifo. It is a synchronous FIFO (width DMA_DATA_W + DMA_DATA_W/8, depth
//   2**FIFO_ADDR_W) with push/pop/full/empty and registered pointers. The data output is valid while
//   !empty (first-word fall-through).
// TESTING
//  1 DMA_DATA_W=32, start_addr=0x1000, xfer_len=4, OKAY -> one AW (awaddr=0x1000, awlen=3, awsize=2),
//    4 W beats with wlast on the 4th, done pulse, error=0.
//  2 start_addr=0x0, xfer_len=600, MAX_BURST=256 -> AWs: (0x000, awlen 255), (0x400, 255), (0x800, 87);
//    600 beats in order; one done pulse.
//  3 start_addr=0xFF8, xfer_len=8 -> AW (0xFF8, awlen 1) then AW (0x1000, awlen 5); no burst crosses 4KB.
//  4 wready random 50%, stream valid gaps, awready delayed 3 cycles -> data order/strobes preserved;
//    wvalid never drops without a handshake; awaddr stable while awvalid.
//  5 xfer_len=600, bresp=SLVERR on burst 2 -> bursts 1-3 all issued, error=1 after done;
//    next start clears error to 0.
//  6 rst pulsed mid-DATA -> all outputs at reset values the next cycle and FIFO empty; a following
//    xfer_len=4 runs cleanly. xfer_len=0 -> done 1 cycle after start, awvalid never asserted.

Source files
------------

// File: rtl/dma_axi_w_burst_pkg.sv
// Shared AXI widths, fixed write-channel attribute values and the burst FSM state type
// for the DMA AXI write master.
package dma_axi_w_burst_pkg;

  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 1;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_QOS_W   = 4;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_4K_W    = 12;

  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_BUF  = 4'b0010;
  localparam logic [AXI_PROT_W-1:0]  AXI_PROT_DATA  = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } w_state_e;

endpackage

// File: rtl/dma_axi_w_burst_fifo.sv
// First-word fall-through synchronous FIFO holding {wstrb, wdata} between the
// stream input and the AXI W channel.
module dma_w_fifo #(
  parameter int WIDTH       = 36,
  parameter int FIFO_ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** FIFO_ADDR_W;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_ADDR_W:0] wr_ptr;
  logic [FIFO_ADDR_W:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_ADDR_W] != rd_ptr[FIFO_ADDR_W]) &&
                   (wr_ptr[FIFO_ADDR_W-1:0] == rd_ptr[FIFO_ADDR_W-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[FIFO_ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[FIFO_ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dma_axi_w_burst.sv
// AXI4 write master: splits one DMA transfer into INCR bursts (<= MAX_BURST beats,
// never crossing 4KB) and feeds W beats from a stream-side FIFO.
module dma_axi_w_burst
  import dma_axi_w_burst_pkg::*;
#(
  parameter int ADDR_W      = AXI_ADDR_W,
  parameter int DMA_DATA_W  = 32,
  parameter int LEN_W       = 16,
  parameter int MAX_BURST   = 256,
  parameter int FIFO_ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [LEN_W-1:0]        xfer_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic                    valid,
  output logic                    ready,
  input  logic [DMA_DATA_W-1:0]   wdata,
  input  logic [DMA_DATA_W/8-1:0] wstrb,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]       m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]    m_axi_awlen,
  output logic [AXI_SIZE_W-1:0]   m_axi_awsize,
  output logic [AXI_BURST_W-1:0]  m_axi_awburst,
  output logic [AXI_LOCK_W-1:0]   m_axi_awlock,
  output logic [AXI_CACHE_W-1:0]  m_axi_awcache,
  output logic [AXI_PROT_W-1:0]   m_axi_awprot,
  output logic [AXI_QOS_W-1:0]    m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DMA_DATA_W-1:0]   m_axi_wdata,
  output logic [DMA_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_RESP_W-1:0]   m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int STRB_W = DMA_DATA_W / 8;
  localparam int AWSIZE = $clog2(STRB_W);
  localparam int BW     = $clog2(MAX_BURST) + 1;
  localparam int FW     = DMA_DATA_W + STRB_W;
  localparam int K4_W   = AXI_4K_W + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << AWSIZE) - 1);

  w_state_e          state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beats_in;
  logic [BW-1:0]     blen;
  logic [BW-1:0]     beat;
  logic [ADDR_W-1:0] addr_next;
  logic [LEN_W-1:0]  rem_next;
  logic [ADDR_W-1:0] start_aligned;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [FW-1:0]     fifo_dout;

  // Burst length limited by remaining beats, MAX_BURST and the distance to the next 4KB page.
  function automatic logic [BW-1:0] calc_blen(input logic [ADDR_W-1:0] a,
                                              input logic [LEN_W-1:0]  r);
    logic [K4_W-1:0] room;
    logic [K4_W-1:0] lim;
    room = (K4_W'(4096) - {1'b0, a[AXI_4K_W-1:0]}) >> AWSIZE;
    lim  = (room > K4_W'(MAX_BURST)) ? K4_W'(MAX_BURST) : room;
    if (32'(r) < 32'(lim)) calc_blen = BW'(r);
    else                   calc_blen = BW'(lim);
  endfunction

  assign start_aligned = start_addr & ~LOW_MASK;
  assign addr_next     = addr + (ADDR_W'(blen) << AWSIZE);
  assign rem_next      = rem - LEN_W'(blen);

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = AXI_LEN_W'(blen - BW'(1));
  assign m_axi_awsize  = AXI_SIZE_W'(AWSIZE);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = '0;
  assign m_axi_awcache = AXI_CACHE_BUF;
  assign m_axi_awprot  = AXI_PROT_DATA;
  assign m_axi_awqos   = '0;

  assign ready        = busy & ~fifo_full & (beats_in < len_q);
  assign push         = valid & ready;
  assign m_axi_wvalid = (state == W_DATA) & ~fifo_empty;
  assign m_axi_wlast  = (state == W_DATA) & (beat == blen - BW'(1));
  assign pop          = m_axi_wvalid & m_axi_wready;
  assign {m_axi_wstrb, m_axi_wdata} = fifo_dout;

  dma_w_fifo #(
    .WIDTH       (FW),
    .FIFO_ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({wstrb, wdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= W_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      addr          <= '0;
      rem           <= '0;
      len_q         <= '0;
      beats_in      <= '0;
      blen          <= '0;
      beat          <= '0;
    end else begin
      done <= 1'b0;
      if (push) beats_in <= beats_in + LEN_W'(1);
      case (state)
        W_IDLE: begin
          if (start) begin
            addr     <= start_aligned;
            rem      <= xfer_len;
            len_q    <= xfer_len;
            beats_in <= '0;
            error    <= 1'b0;
            if (xfer_len == '0) begin
              done <= 1'b1;
            end else begin
              busy          <= 1'b1;
              blen          <= calc_blen(start_aligned, xfer_len);
              m_axi_awvalid <= 1'b1;
              state         <= W_ADDR;
            end
          end
        end
        W_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            beat          <= '0;
            state         <= W_DATA;
          end
        end
        W_DATA: begin
          if (pop) begin
            beat <= beat + BW'(1);
            if (m_axi_wlast) begin
              m_axi_bready <= 1'b1;
              state        <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            error        <= error | (m_axi_bresp != AXI_RESP_OKAY);
            rem          <= rem_next;
            addr         <= addr_next;
            // Errors never abort: remaining bursts are still issued.
            if (rem_next != '0) begin
              blen          <= calc_blen(addr_next, rem_next);
              m_axi_awvalid <= 1'b1;
              state         <= W_ADDR;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= W_IDLE;
            end
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule
